// File: rtl/elevator_pkg.sv
// Shared types and constants for the four-floor elevator controller.
// Holds the FSM state encoding, segment codes and datapath widths.
package elevator_pkg;

    localparam int FLOOR_W = 2;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_UP,
        ST_DOWN,
        ST_HALT
    } state_t;

    // Active-high segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;

    function automatic logic [6:0] seg_decode(
        input logic [FLOOR_W-1:0] f
    );
        logic [6:0] seg;
        case (f)
            2'd0:    seg = SEG_0;
            2'd1:    seg = SEG_1;
            2'd2:    seg = SEG_2;
            default: seg = SEG_3;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/top_clk_div.sv
// Step-clock divider: clk_delay toggles every HALF_PERIOD cycles.
// step is high for one cycle right after each 0->1 toggle of clk_delay.
module clk_div #(
    parameter int HALF_PERIOD = 1
) (
    input  logic clk,
    input  logic rst,
    output logic clk_delay,
    output logic step
);

    localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

    logic [CW-1:0] r_cnt;
    logic          r_clk_delay;
    logic          r_step;
    logic          w_wrap;

    assign w_wrap = (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_clk_delay <= 1'b0;
            r_step      <= 1'b0;
        end else begin
            r_step <= w_wrap && !r_clk_delay;
            if (w_wrap) begin
                r_cnt       <= '0;
                r_clk_delay <= ~r_clk_delay;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign clk_delay = r_clk_delay;
    assign step      = r_step;

endmodule

// File: rtl/top.sv
// Four-floor elevator controller: direction FSM, floor register,
// floor-change counter and 7-segment decode, paced by clk_div steps.
module top
    import elevator_pkg::*;
#(
    parameter int HALF_PERIOD = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               stop,
    input  logic [FLOOR_W-1:0] in,
    output logic               clk_delay,
    output logic [6:0]         floor_display,
    output logic [CNT_W-1:0]   changes_count
);

    state_t             r_state;
    state_t             w_next;
    logic [FLOOR_W-1:0] r_floor;
    logic [CNT_W-1:0]   r_count;
    logic               w_step;
    logic               w_move_ok;

    clk_div #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_clk_div (
        .clk      (clk),
        .rst      (rst),
        .clk_delay(clk_delay),
        .step     (w_step)
    );

    always_comb begin
        w_next = ST_IDLE;
        if (!en || stop)
            w_next = ST_HALT;
        else if (in > r_floor)
            w_next = ST_UP;
        else if (in < r_floor)
            w_next = ST_DOWN;
        else
            w_next = ST_IDLE;
    end

    // Live en/stop veto the move even if the registered state says go
    assign w_move_ok = w_step && en && !stop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_floor <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_move_ok) begin
                case (r_state)
                    ST_UP: begin
                        r_floor <= r_floor + 1'b1;
                        r_count <= r_count + 1'b1;
                    end
                    ST_DOWN: begin
                        r_floor <= r_floor - 1'b1;
                        r_count <= r_count + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign floor_display = seg_decode(r_floor);
    assign changes_count = r_count;

endmodule

// File: tb/tb_top.sv
// Self-checking bench for the elevator controller top.
// Vector table plus hand sequences for stop-on-step and async reset.
module tb_top;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       stop = 1'b0;
    logic [1:0] req = 2'd0;
    logic       clk_delay;
    logic [6:0] floor_display;
    logic [3:0] changes_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       en;
        logic       stop;
        logic [1:0] req;
        int         cyc;
        logic [6:0] disp;
        logic [3:0] cnt;
    } vec_t;

    typedef struct {
        logic [6:0] disp;
        logic [3:0] cnt;
        logic       cd;
    } exp_t;

    exp_t sb[$];
    vec_t vt[13];

    top #(
        .HALF_PERIOD(1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .stop         (stop),
        .in           (req),
        .clk_delay    (clk_delay),
        .floor_display(floor_display),
        .changes_count(changes_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        en   = v.en;
        stop = v.stop;
        req  = v.req;
        sb.push_back('{v.disp, v.cnt, 1'b0});
        run(v.cyc);
        e = sb.pop_front();
        check($sformatf("vec%0d display", idx), 32'(floor_display), 32'(e.disp));
        check($sformatf("vec%0d count", idx), 32'(changes_count), 32'(e.cnt));
        check($sformatf("vec%0d clk_delay", idx), 32'(clk_delay), 32'(e.cd));
    endtask

    initial begin
        // en, stop, in, cycles, display, count
        vt[0]  = '{1'b1, 1'b0, 2'd3, 2,  7'h06, 4'd1};
        vt[1]  = '{1'b1, 1'b0, 2'd3, 2,  7'h5B, 4'd2};
        vt[2]  = '{1'b1, 1'b0, 2'd3, 2,  7'h4F, 4'd3};
        vt[3]  = '{1'b1, 1'b0, 2'd3, 4,  7'h4F, 4'd3};
        vt[4]  = '{1'b1, 1'b0, 2'd1, 2,  7'h5B, 4'd4};
        vt[5]  = '{1'b1, 1'b0, 2'd1, 2,  7'h06, 4'd5};
        vt[6]  = '{1'b1, 1'b1, 2'd2, 4,  7'h06, 4'd5};
        vt[7]  = '{1'b1, 1'b0, 2'd2, 2,  7'h5B, 4'd6};
        vt[8]  = '{1'b0, 1'b0, 2'd0, 10, 7'h5B, 4'd6};
        vt[9]  = '{1'b1, 1'b0, 2'd0, 2,  7'h06, 4'd7};
        vt[10] = '{1'b1, 1'b0, 2'd0, 4,  7'h3F, 4'd10};
        vt[11] = '{1'b1, 1'b0, 2'd3, 6,  7'h4F, 4'd13};
        vt[12] = '{1'b1, 1'b0, 2'd0, 6,  7'h3F, 4'd0};

        // Reset held with a pending request: nothing may move
        rst  = 1'b0;
        en   = 1'b1;
        stop = 1'b0;
        req  = 2'd3;
        @(negedge clk);
        run(3);
        check("reset display", 32'(floor_display), 32'h3F);
        check("reset count", 32'(changes_count), 32'd0);
        check("reset clk_delay", 32'(clk_delay), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 10; i++)
            apply(vt[i], i);

        // Stop raised during the step cycle suppresses that step
        en   = 1'b1;
        stop = 1'b0;
        req  = 2'd3;
        run(1);
        check("step cycle clk_delay", 32'(clk_delay), 32'd1);
        stop = 1'b1;
        run(1);
        check("stop on step display", 32'(floor_display), 32'h06);
        check("stop on step count", 32'(changes_count), 32'd7);
        stop = 1'b0;
        run(2);
        check("after stop display", 32'(floor_display), 32'h5B);
        check("after stop count", 32'(changes_count), 32'd8);

        // Alternate 0/3 requests until the counter wraps to zero
        for (int i = 10; i < 13; i++)
            apply(vt[i], i);

        // Asynchronous reset between edges while travelling
        req = 2'd3;
        run(2);
        check("pre-reset display", 32'(floor_display), 32'h06);
        check("pre-reset count", 32'(changes_count), 32'd1);
        run(1);
        #2 rst = 1'b0;
        #1;
        check("async reset display", 32'(floor_display), 32'h3F);
        check("async reset count", 32'(changes_count), 32'd0);
        check("async reset clk_delay", 32'(clk_delay), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run(1);
        check("first edge no step", 32'(floor_display), 32'h3F);
        run(1);
        check("second edge step display", 32'(floor_display), 32'h06);
        check("second edge step count", 32'(changes_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
